// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel synchroniser, debounce FSM, one-clock press
// pulse and long-press auto-repeat, with registered level/pulse outputs.
module button_conditioner #(
  parameter int N_BTN           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             en,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             any_pulse
);

  // Terminal counts: a counter sitting at X_LAST has seen X samples/cycles.
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } state_t;

  logic [N_BTN-1:0] pulse_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   level_q, level_d;
    logic                   pulse_raw;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: every output of this block is given a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      pulse_raw = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s) begin
            state_d = DB_PRESS;
            cnt_d   = '0;
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d   = HELD;
            level_d   = 1'b1;
            pulse_raw = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          // With repeat disabled the counter simply holds its value.
          if (!s) begin
            state_d = DB_RELEASE;
            cnt_d   = '0;
          end else if (repeat_en[i]) begin
            if (cnt_q == DELAY_LAST) begin
              state_d   = REPEAT;
              pulse_raw = 1'b1;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        REPEAT: begin
          if (!s) begin
            state_d = DB_RELEASE;
            cnt_d   = '0;
          end else if (!repeat_en[i]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == PERIOD_LAST) begin
            pulse_raw = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DB_RELEASE: begin
          // A bounce back to 1 returns to HELD without a fresh press pulse.
          if (s) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign btn_level[i] = level_q;
    assign pulse_d[i]   = pulse_raw & en;
  end

  // Masked pulses are dropped here, so the FSMs never see en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_pulse <= '0;
      any_pulse <= 1'b0;
    end else begin
      btn_pulse <= pulse_d;
      any_pulse <= |pulse_d;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized bouncing, all
// compared every cycle against a run-length based behavioural model.
module tb_button_conditioner;
  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in, repeat_en, btn_level, btn_pulse;
  logic         en, any_pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .en(en), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .any_pulse(any_pulse)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: debounced level flips after DB+1 consecutive samples opposite to it
  // (the first one is what leaves the idle/held condition).
  logic [N-1:0] hist [SYNC];
  logic [N-1:0] m_lvl, m_pulse, m_out;
  int           m_run [N];
  int           m_elapsed [N];
  bit           m_repeating [N];

  logic [N-1:0] obs_pulse [64];
  logic [N-1:0] obs_level [64];
  int           edge_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) hist[i] = '0;
    m_lvl = '0; m_pulse = '0; m_out = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_elapsed[c] = 0; m_repeating[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    bit restart;
    s = hist[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = btn_in;
    m_pulse = '0;
    for (int c = 0; c < N; c++) begin
      restart = 0;
      if (s[c] != m_lvl[c]) m_run[c]++;
      else begin
        restart = m_lvl[c] && (m_run[c] > 0);
        m_run[c] = 0;
      end
      if (m_run[c] == DB + 1) begin
        m_lvl[c] = ~m_lvl[c];
        m_run[c] = 0;
        if (m_lvl[c]) begin
          m_pulse[c] = 1'b1; m_elapsed[c] = 0; m_repeating[c] = 0;
        end
      end else if (restart) begin
        m_elapsed[c] = 0; m_repeating[c] = 0;
      end else if (m_lvl[c] && m_run[c] == 0) begin
        if (!repeat_en[c]) begin
          if (m_repeating[c]) begin m_repeating[c] = 0; m_elapsed[c] = 0; end
        end else begin
          m_elapsed[c]++;
          if (m_elapsed[c] == (m_repeating[c] ? RP : RD)) begin
            m_pulse[c] = 1'b1; m_elapsed[c] = 0; m_repeating[c] = 1;
          end
        end
      end
    end
    m_out = m_pulse & {N{en}};
  endtask

  task automatic begin_test();
    edge_n = 0;
    for (int e = 0; e < 64; e++) begin obs_pulse[e] = '0; obs_level[e] = '0; end
  endtask

  // Drive one input vector, let one posedge happen, compare at the next negedge.
  task automatic step(input logic [N-1:0] b);
    btn_in = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("btn_level", btn_level, m_lvl);
    check("btn_pulse", btn_pulse, m_out);
    check("any_pulse", any_pulse, |m_out);
    if (edge_n < 64) begin
      obs_pulse[edge_n] = btn_pulse;
      obs_level[edge_n] = btn_level;
    end
    edge_n++;
  endtask

  function automatic int pulse_count(input int ch, input int lo, input int hi);
    int n = 0;
    for (int e = lo; e <= hi; e++) n += obs_pulse[e][ch];
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t3 [7];
    int t4 [5];
    logic [N-1:0] rb;
    t3 = '{6, 16, 19, 22, 25, 28, 31};
    t4 = '{6, 26, 29, 32, 35};

    rst_n = 1'b0; btn_in = '0; en = 1'b1; repeat_en = '0;
    model_reset();
    #3;
    check("reset_level", btn_level, 3'b000);
    check("reset_pulse", {any_pulse, btn_pulse}, 4'b0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Clean press on channel 0, no repeat.
    begin_test();
    repeat (8) step(3'b001);
    repeat (10) step(3'b000);
    check("t1_pulse_edge6", obs_pulse[6], 3'b001);
    check("t1_one_pulse", pulse_count(0, 0, 17), 1);
    check("t1_rise_edge6", {obs_level[5][0], obs_level[6][0]}, 2'b01);
    check("t1_fall_edge14", {obs_level[13][0], obs_level[14][0]}, 2'b10);

    // Bounce on channel 1: last rising sample at edge 5.
    begin_test();
    step(3'b010); step(3'b000); step(3'b010); step(3'b010); step(3'b000);
    repeat (12) step(3'b010);
    repeat (10) step(3'b000);
    check("t2_pulse_edge11", obs_pulse[11], 3'b010);
    check("t2_one_pulse", pulse_count(1, 0, 26), 1);

    // Auto-repeat on channel 2.
    repeat_en = 3'b100;
    begin_test();
    repeat (30) step(3'b100);
    repeat (12) step(3'b000);
    foreach (t3[i]) check("t3_repeat_edge", {24'd0, obs_pulse[t3[i]]}, 3'b100);
    check("t3_pulse_total", pulse_count(2, 0, 41), 7);

    // Release glitch on channel 0 while held with repeat enabled.
    repeat_en = 3'b001;
    begin_test();
    repeat (12) step(3'b001);
    repeat (2) step(3'b000);
    repeat (20) step(3'b001);
    repeat (12) step(3'b000);
    check("t4_level_held", {obs_level[14][0], obs_level[15][0], obs_level[16][0]}, 3'b111);
    foreach (t4[i]) check("t4_pulse_edge", {24'd0, obs_pulse[t4[i]]}, 3'b001);
    check("t4_pulse_total", pulse_count(0, 0, 45), 5);
    repeat_en = 3'b000;

    // Simultaneous press, then the same with pulses masked.
    begin_test();
    repeat (10) step(3'b111);
    repeat (10) step(3'b000);
    check("t5_simul_pulse", obs_pulse[6], 3'b111);
    en = 1'b0;
    begin_test();
    repeat (10) step(3'b111);
    repeat (10) step(3'b000);
    check("t5_masked_level", {obs_level[5], obs_level[6]}, 6'b000111);
    check("t5_masked_pulses", pulse_count(0, 0, 19) + pulse_count(1, 0, 19) + pulse_count(2, 0, 19), 0);
    en = 1'b1;

    // Asynchronous reset while channel 0 is held.
    begin_test();
    repeat (10) step(3'b001);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_reset_level", btn_level, 3'b000);
    check("t6_reset_pulse", {any_pulse, btn_pulse}, 4'b0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    begin_test();
    repeat (10) step(3'b001);
    repeat (10) step(3'b000);
    check("t6_repress_edge6", obs_pulse[6], 3'b001);
    check("t6_one_pulse", pulse_count(0, 0, 19), 1);

    // Randomized bouncing with random en and repeat_en changes.
    rb = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) en = ~en;
      if ($urandom_range(31) == 0) repeat_en[$urandom_range(N-1)] ^= 1'b1;
      for (int c = 0; c < N; c++)
        if ($urandom_range(5) == 0) rb[c] = ~rb[c];
      step(rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
